// File: rtl/clkdiv_scheduler.sv
// Multi-channel programmable clock-enable generator: per-channel terminal-count
// divider producing a one-cycle tick and a 2*D square wave, configured via valid/ready.
module clkdiv_scheduler #(
  parameter int                  CHANNELS    = 4,
  parameter int                  CNT_W       = 16,
  parameter int                  DEFAULT_DIV = 100,
  parameter logic [CHANNELS-1:0] RESET_EN    = 'b1,
  localparam int                 CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic                cfg_enable,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] scaled,
  output logic [CHANNELS-1:0] running,
  output logic [CHANNELS-1:0] pending
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RUN_PEND} state_t;

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  localparam logic [CNT_W-1:0] DEF_DIV = clamp_div(CNT_W'(DEFAULT_DIV));

  state_t              r_state     [CHANNELS];
  state_t              w_state_nxt [CHANNELS];
  logic [CNT_W-1:0]    r_cnt       [CHANNELS];
  logic [CNT_W-1:0]    r_div       [CHANNELS];
  logic [CNT_W-1:0]    r_pdiv      [CHANNELS];
  logic [CHANNELS-1:0] r_tick;
  logic [CHANNELS-1:0] r_scaled;
  logic [CHANNELS-1:0] w_wr;
  logic [CHANNELS-1:0] w_term;
  logic [CHANNELS-1:0] w_running;
  logic [CHANNELS-1:0] w_pending;
  logic                w_ready;
  logic [CNT_W-1:0]    w_div;

  assign w_div = clamp_div(cfg_div);

  // Out-of-range channel indices match no channel: accepted and dropped.
  always_comb begin
    w_ready = 1'b1;
    w_wr    = '0;
    w_term  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CH_W'(i)) w_ready = ~w_pending[i];
      w_term[i] = (r_cnt[i] == r_div[i] - CNT_W'(1));
    end
    for (int i = 0; i < CHANNELS; i++) begin
      w_wr[i] = cfg_valid && w_ready && (cfg_chan == CH_W'(i));
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset) r_state[i] <= RESET_EN[i] ? S_RUN : S_IDLE;
      else       r_state[i] <= w_state_nxt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_state_nxt[i] = r_state[i];
      unique case (r_state[i])
        S_IDLE:     if (w_wr[i] && cfg_enable) w_state_nxt[i] = S_RUN;
        S_RUN:      if (w_wr[i]) w_state_nxt[i] = cfg_enable ? S_RUN_PEND : S_IDLE;
        S_RUN_PEND: begin
          if (w_wr[i] && !cfg_enable) w_state_nxt[i] = S_IDLE;
          else if (w_term[i])         w_state_nxt[i] = S_RUN;
        end
        default:    w_state_nxt[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_running = '0;
    w_pending = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_running[i] = (r_state[i] != S_IDLE);
      w_pending[i] = (r_state[i] == S_RUN_PEND);
    end
  end

  // A write landing on a terminal-count edge is only latched into r_pdiv;
  // the divisor in force for that edge is still the old one.
  always_ff @(posedge clock) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset) begin
        r_cnt[i]    <= '0;
        r_div[i]    <= DEF_DIV;
        r_pdiv[i]   <= DEF_DIV;
        r_tick[i]   <= 1'b0;
        r_scaled[i] <= 1'b0;
      end else if (r_state[i] == S_IDLE) begin
        r_cnt[i]    <= '0;
        r_tick[i]   <= 1'b0;
        r_scaled[i] <= 1'b0;
        if (w_wr[i]) r_div[i] <= w_div;
      end else if (w_wr[i] && !cfg_enable) begin
        r_cnt[i]    <= '0;
        r_tick[i]   <= 1'b0;
        r_scaled[i] <= 1'b0;
        r_div[i]    <= w_div;
      end else begin
        if (w_term[i]) begin
          r_cnt[i]    <= '0;
          r_tick[i]   <= 1'b1;
          r_scaled[i] <= ~r_scaled[i];
          if (r_state[i] == S_RUN_PEND) r_div[i] <= r_pdiv[i];
        end else begin
          r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
          r_tick[i] <= 1'b0;
        end
        if (w_wr[i]) r_pdiv[i] <= w_div;
      end
    end
  end

  assign cfg_ready = w_ready;
  assign tick      = r_tick;
  assign scaled    = r_scaled;
  assign running   = w_running;
  assign pending   = w_pending;

endmodule

// File: tb/tb_clkdiv_scheduler.sv
// Directed bench for clkdiv_scheduler: hand-computed tick/scaled/handshake
// expectations indexed by edge number since reset.
module tb_clkdiv_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_chan = '0;
  logic [15:0] cfg_div = '0;
  logic        cfg_enable = 1'b0;
  logic [3:0]  tick, scaled, running, pending;

  int n_checks = 0;
  int n_fail   = 0;

  clkdiv_scheduler #(
    .CHANNELS(4), .CNT_W(16), .DEFAULT_DIV(100), .RESET_EN(4'b0001)
  ) dut (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_div(cfg_div), .cfg_enable(cfg_enable),
    .tick(tick), .scaled(scaled), .running(running), .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_wr(input logic [1:0] ch, input logic [15:0] d, input logic en);
    cfg_valid  = 1'b1;
    cfg_chan   = ch;
    cfg_div    = d;
    cfg_enable = en;
  endtask

  initial begin
    // Reset; edges below are numbered from the reset edge E0.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_eq("rst_running", 32'(running), 32'h1);
    check_eq("rst_pending", 32'(pending), 32'h0);
    check_eq("rst_tick",    32'(tick),    32'h0);
    check_eq("rst_scaled",  32'(scaled),  32'h0);
    check_eq("rst_ready",   32'(cfg_ready), 32'h1);

    // Default divisor 100 on ch0
    step(99);                                     // E99
    check_eq("ch0_pre_tick", 32'(tick), 32'h0);
    step(1);                                      // E100
    check_eq("ch0_tick100",  32'(tick),   32'h1);
    check_eq("ch0_scl100",   32'(scaled), 32'h1);
    step(1);                                      // E101
    check_eq("ch0_tick101",  32'(tick),   32'h0);
    step(99);                                     // E200
    check_eq("ch0_tick200",  32'(tick),   32'h1);
    check_eq("ch0_scl200",   32'(scaled), 32'h0);

    // Ch2 D=5 enable
    drive_wr(2'd2, 16'd5, 1'b1);
    #1 check_eq("ch2_ready", 32'(cfg_ready), 32'h1);
    step(1);                                      // E201 accept
    cfg_valid = 1'b0;
    check_eq("ch2_running", 32'(running), 32'h5);
    step(4);                                      // E205
    check_eq("ch2_tick205", 32'(tick[2]), 32'h0);
    step(1);                                      // E206
    check_eq("ch2_tick206", 32'(tick[2]), 32'h1);
    check_eq("ch2_scl206",  32'(scaled[2]), 32'h1);
    step(1);                                      // E207
    check_eq("ch2_tick207", 32'(tick[2]), 32'h0);
    step(4);                                      // E211
    check_eq("ch2_tick211", 32'(tick[2]), 32'h1);
    check_eq("ch2_scl211",  32'(scaled[2]), 32'h0);

    // Ch2 retarget to D=3 at cnt=1, then a stalled D=9 write
    step(1);                                      // E212, cnt=1
    drive_wr(2'd2, 16'd3, 1'b1);
    step(1);                                      // E213 accept
    drive_wr(2'd2, 16'd9, 1'b1);
    #1;
    check_eq("ch2_pend",     32'(pending),   32'h4);
    check_eq("ch2_stall_rdy", 32'(cfg_ready), 32'h0);
    step(2);                                      // E215
    check_eq("ch2_tick215",  32'(tick[2]), 32'h0);
    check_eq("ch2_pend215",  32'(pending), 32'h4);
    step(1);                                      // E216: old period of 5 ends
    check_eq("ch2_tick216",  32'(tick[2]), 32'h1);
    check_eq("ch2_scl216",   32'(scaled[2]), 32'h1);
    check_eq("ch2_pclr216",  32'(pending), 32'h0);
    check_eq("ch2_rdy216",   32'(cfg_ready), 32'h1);
    step(1);                                      // E217 stalled write accepted
    cfg_valid = 1'b0;
    check_eq("ch2_pend217",  32'(pending), 32'h4);
    check_eq("ch2_tick217",  32'(tick[2]), 32'h0);
    step(1);                                      // E218
    check_eq("ch2_tick218",  32'(tick[2]), 32'h0);
    step(1);                                      // E219 first D=3 period
    check_eq("ch2_tick219",  32'(tick[2]), 32'h1);
    check_eq("ch2_pclr219",  32'(pending), 32'h0);
    step(8);                                      // E227
    check_eq("ch2_tick227",  32'(tick[2]), 32'h0);
    step(1);                                      // E228 first D=9 period
    check_eq("ch2_tick228",  32'(tick[2]), 32'h1);

    // Ch1 D=0 clamps to 1
    drive_wr(2'd1, 16'd0, 1'b1);
    step(1);                                      // E229 accept
    cfg_valid = 1'b0;
    check_eq("ch1_running",  32'(running[1]), 32'h1);
    check_eq("ch1_tick229",  32'(tick[1]), 32'h0);
    step(1);                                      // E230
    check_eq("ch1_tick230",  32'(tick[1]),   32'h1);
    check_eq("ch1_scl230",   32'(scaled[1]), 32'h1);
    step(1);                                      // E231
    check_eq("ch1_tick231",  32'(tick[1]),   32'h1);
    check_eq("ch1_scl231",   32'(scaled[1]), 32'h0);
    step(1);                                      // E232
    check_eq("ch1_scl232",   32'(scaled[1]), 32'h1);

    // Ch0 stop at cnt=50, then re-enable with D=7
    step(18);                                     // E250, ch0 cnt=50
    drive_wr(2'd0, 16'd7, 1'b0);
    step(1);                                      // E251 stop
    cfg_valid = 1'b0;
    check_eq("ch0_stop_run", 32'(running), 32'h6);
    check_eq("ch0_stop_tick", 32'(tick[0]), 32'h0);
    check_eq("ch0_stop_scl", 32'(scaled[0]), 32'h0);
    step(3);                                      // E254
    check_eq("ch0_idle_tick", 32'(tick[0]), 32'h0);
    drive_wr(2'd0, 16'd7, 1'b1);
    step(1);                                      // E255 accept
    cfg_valid = 1'b0;
    step(6);                                      // E261
    check_eq("ch0_tick261",  32'(tick[0]), 32'h0);
    step(1);                                      // E262: ch0 and ch1 tick together
    check_eq("tick_vec262",  32'(tick), 32'h3);
    check_eq("ch0_scl262",   32'(scaled[0]), 32'h1);

    // Stop ch1 while its scaled output is high
    drive_wr(2'd1, 16'd4, 1'b0);
    step(1);                                      // E263
    cfg_valid = 1'b0;
    check_eq("ch1_stop_scl",  32'(scaled[1]), 32'h0);
    check_eq("ch1_stop_tick", 32'(tick[1]),   32'h0);
    check_eq("ch1_stop_run",  32'(running),   32'h5);

    // Ch3 pending, then reset (with a concurrent write that must be dropped)
    drive_wr(2'd3, 16'd4, 1'b1);
    step(1);                                      // E264
    drive_wr(2'd3, 16'd6, 1'b1);
    step(1);                                      // E265
    check_eq("ch3_pend",     32'(pending), 32'h8);
    drive_wr(2'd1, 16'd5, 1'b1);
    reset = 1'b1;
    step(1);                                      // new reset edge R0
    reset = 1'b0;
    cfg_valid = 1'b0;
    check_eq("rst2_pending", 32'(pending), 32'h0);
    check_eq("rst2_running", 32'(running), 32'h1);
    check_eq("rst2_scaled",  32'(scaled),  32'h0);
    check_eq("rst2_tick",    32'(tick),    32'h0);
    step(99);                                     // R99
    check_eq("rst2_tick99",  32'(tick), 32'h0);
    step(1);                                      // R100
    check_eq("rst2_tick100", 32'(tick), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clkdiv_scheduler.md
Name: clkdiv_scheduler

Overview:
- Multi-channel programmable clock-enable generator and controller.
- Each channel has a terminal-count counter that produces a single-cycle tick and a divided square wave.
- Divisors and run/stop state are configured through one valid/ready write port.
- Divisor changes on a running channel are deferred to that channel's next terminal count, so no runt periods occur. Downstream timing logic (display refresh, debouncers, slow FSMs) consumes the ticks.

Parameters:
CHANNELS, 4, number of independent divider channels (1..16)
CNT_W, 16, counter/divisor width in bits
DEFAULT_DIV, 100, divisor loaded into every channel at reset
RESET_EN, 4'b0001, per-channel run state after reset (bit i = channel i)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
cfg_valid  input  1  configuration write request
cfg_ready  output  1  write can be accepted this cycle
cfg_chan  input  max(1,$clog2(CHANNELS))  target channel index
cfg_div  input  CNT_W  new divisor D
cfg_enable  input  1  1 = channel runs, 0 = channel stops
tick  output  CHANNELS  one-cycle pulse per channel at terminal count (registered)
scaled  output  CHANNELS  divided clock per channel, toggles at each terminal count (registered)
running  output  CHANNELS  channel enabled
pending  output  CHANNELS  deferred divisor waiting for terminal count

Behaviour:
- **Reset** (reset=1 at an edge): div[i]=DEFAULT_DIV, cnt[i]=0, running=RESET_EN, pending=0, tick=0, scaled=0. Reset dominates any cfg write in the same cycle.
- **Divisor clamp:** an effective D of 0 is stored as 1.
- **Per-channel states:** IDLE, RUN, RUN_PEND.
- **RUN count:**
  - cnt increments each edge.
  - At the edge where cnt==div-1: cnt<=0, tick[i]<=1 for exactly that following cycle, scaled[i]<=~scaled[i].
  - At all other edges tick[i]<=0.
  - Tick period = D cycles; scaled period = 2D cycles.
  - D=1: tick held high continuously; scaled toggles every cycle.
- **Handshake:**
  - cfg_ready = ~pending[cfg_chan] (combinational on cfg_chan).
  - A write is accepted when cfg_valid && cfg_ready at a rising edge.
  - A write with cfg_chan >= CHANNELS is accepted and ignored.
- **Accepted write, target IDLE, enable=1:** div<=D, cnt<=0, scaled<=0 → RUN. The first tick is high during the cycle after the D-th edge following acceptance.
- **Accepted write, target IDLE, enable=0:** div<=D only; channel stays IDLE.
- **Accepted write, target RUN, enable=1:** pend_div<=D, pending<=1 → RUN_PEND. Counting continues with the old divisor.
- **Accepted write, target RUN or RUN_PEND, enable=0:** immediate stop → IDLE. cnt<=0, tick<=0, scaled<=0, pending<=0, div<=D.
- **RUN_PEND at terminal count:** normal tick/toggle. div<=pend_div, cnt<=0, pending<=0 → RUN. The next period uses the new D.
- **Write to RUN_PEND with enable=1:** blocked (cfg_ready=0); the requester holds cfg_valid.
- **Write coinciding with terminal count on a RUN channel:** the terminal count completes with the old div, and the write is pended. It applies at the following terminal count, not the current one.
- **IDLE outputs:** tick=0, scaled=0, cnt frozen at 0.
- **Counter range:** cnt never exceeds div-1. Wrap is by terminal compare only, with no modular overflow for any D up to 2^CNT_W-1.
- **Reset mid-operation:** all pending writes discarded; state returns to reset values on the next edge.
- **Independence:** channels are fully independent; simultaneous terminal counts on different channels each produce their own tick.

Test Plan:
1. Reset, no writes → ch0: tick high 1 cycle every 100 cycles, first tick in the cycle after edge 100; scaled[0] period 200 cycles; ch1-3 tick=0, scaled=0, running=4'b0001.
2. Write ch2 D=5 enable=1 → cfg_ready=1, accepted; running[2]=1; tick[2] every 5 cycles; scaled[2] period 10.
3. Ch2 running D=5; write D=3 at cnt=1 → pending[2]=1 and cfg_ready=0 for ch2; the remaining period is 5 cycles; subsequent ticks are 3 apart; pending clears at that terminal count; a second ch2 write stalls until then.
4. Write ch1 D=0 enable=1 → stored as 1; tick[1] continuously high; scaled[1] toggles every cycle.
5. Ch0 running at cnt=50; write ch0 enable=0 D=7 → next cycle running[0]=0, tick[0]=0, scaled[0]=0; re-enable later → first tick 7 cycles after acceptance.
6. Ch3 with pending divisor, assert reset for 1 cycle → pending=0, div=100 on all channels, running=4'b0001, all scaled=0.
